// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: turns a UART byte stream into memory-mapped bus accesses
// and sends the response bytes back through the UART transmitter.
//   'W' A3..A0 D3..D0 -> write, responds ACK_BYTE
//   'R' A3..A0        -> read, responds R3..R0
//   anything else     -> NAK_BYTE
// Optional feature macro: UART_DBG_BRIDGE_AUTOINC_EN
//   adds 'w'/'r' (reuse current address) and post-access address += 4.
module uart_dbg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 640000,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR       = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_BUS        = 3'd3;
  localparam logic [2:0] S_RESP_LOAD  = 3'd4;
  localparam logic [2:0] S_RESP_GUARD = 3'd5;
  localparam logic [2:0] S_RESP_WAIT  = 3'd6;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
`ifdef UART_DBG_BRIDGE_AUTOINC_EN
  localparam logic [7:0] CMD_WRITE_INC = 8'h77;
  localparam logic [7:0] CMD_READ_INC  = 8'h72;
`endif

  // Last count value before the timeout fires; unused when the timeout is disabled.
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;

  logic [2:0]  r_state;
  logic        r_is_write;
  logic [1:0]  r_cnt;
  logic [31:0] r_tmo;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_tx_data;
  logic [23:0] r_resp;   // response bytes still to be sent, MSB first
  logic [1:0]  r_left;   // number of bytes remaining in r_resp
  logic        w_in_cmd;
  logic        w_tmo_hit;

  assign w_in_cmd  = (r_state == S_ADDR) || (r_state == S_DATA);
  // A byte arriving in the match cycle wins over the timeout.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_in_cmd && !rx_valid && (r_tmo == TMO_LAST);

  assign tx_en     = (r_state == S_RESP_LOAD);
  assign tx_data   = r_tx_data;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = (r_state == S_BUS) && r_is_write;
  assign mem_re    = (r_state == S_BUS) && !r_is_write;
  assign busy      = (r_state != S_IDLE);

  // Inter-byte idle counter, only live while collecting command fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= 32'd0;
    end else if (w_in_cmd && !rx_valid && !w_tmo_hit && (TIMEOUT_CYCLES != 0)) begin
      r_tmo <= r_tmo + 32'd1;
    end else begin
      r_tmo <= 32'd0;
    end
  end

  // Command decode, field collection, bus access and response sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_tx_data  <= 8'd0;
      r_resp     <= 24'd0;
      r_left     <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_cnt <= 2'd0;
            if (rx_data == CMD_WRITE) begin
              r_is_write <= 1'b1;
              r_state    <= S_ADDR;
            end else if (rx_data == CMD_READ) begin
              r_is_write <= 1'b0;
              r_state    <= S_ADDR;
`ifdef UART_DBG_BRIDGE_AUTOINC_EN
            end else if (rx_data == CMD_WRITE_INC) begin
              r_is_write <= 1'b1;
              r_state    <= S_DATA;
            end else if (rx_data == CMD_READ_INC) begin
              r_is_write <= 1'b0;
              r_state    <= S_BUS;
`endif
            end else begin
              r_tx_data <= NAK_BYTE;
              r_left    <= 2'd0;
              r_state   <= S_RESP_LOAD;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= {r_addr[23:0], rx_data};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= r_is_write ? S_DATA : S_BUS;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wdata <= {r_wdata[23:0], rx_data};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_BUS;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_BUS: begin
          if (r_is_write) begin
            r_tx_data <= ACK_BYTE;
            r_left    <= 2'd0;
          end else begin
            r_tx_data <= mem_rdata[31:24];
            r_resp    <= mem_rdata[23:0];
            r_left    <= 2'd3;
          end
`ifdef UART_DBG_BRIDGE_AUTOINC_EN
          r_addr <= r_addr + 32'd4;
`endif
          r_state <= S_RESP_LOAD;
        end
        S_RESP_LOAD: begin
          r_state <= S_RESP_GUARD;
        end
        S_RESP_GUARD: begin
          // Transmitter may not have raised tx_busy yet; do not look at it here.
          r_state <= S_RESP_WAIT;
        end
        S_RESP_WAIT: begin
          if (!tx_busy) begin
            if (r_left != 2'd0) begin
              r_tx_data <= r_resp[23:16];
              r_resp    <= {r_resp[15:0], 8'h00};
              r_left    <= r_left - 2'd1;
              r_state   <= S_RESP_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Self-checking bench for uart_dbg_bridge (TIMEOUT_CYCLES = 100).
module tb_uart_dbg_bridge;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        busy;

  uart_dbg_bridge #(
    .TIMEOUT_CYCLES(100),
    .ACK_BYTE      (8'h4B),
    .NAK_BYTE      (8'h3F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nchecks = 0;
  int          nerr = 0;
  logic [7:0]  tx_log[$];
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [31:0] we_addr;
  logic [31:0] we_data;
  logic [31:0] re_addr;
  logic [31:0] rdata_val;

  assign mem_rdata = rdata_val;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transmitter model (busy rises one cycle after tx_en, lasts 6 cycles) and bus monitor.
  initial begin
    int busy_left;
    bit pend;
    busy_left = 0;
    pend = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        check32("tx_en_while_busy", {31'd0, tx_busy}, 32'd0);
        tx_log.push_back(tx_data);
      end
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (mem_re) begin
        re_cnt++;
        re_addr = mem_addr;
      end
      if (pend) begin
        tx_busy = 1'b1;
        busy_left = 6;
        pend = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (tx_en) pend = 1'b1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input bit has_addr, input bit has_data);
    send_byte(cmd, 1);
    if (has_addr) for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], 1);
    if (has_data) for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8], 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check32(name, (n < 400) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] resp_since(input int base);
    logic [31:0] r;
    r = 32'd0;
    for (int i = base; i < tx_log.size(); i++) r = {r[23:0], tx_log[i]};
    return r;
  endfunction

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          exp_we;
    int          exp_re;
    int          exp_n;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base_tx;
    int base_we;
    int base_re;
    bit ha;

    vecs[0] = '{8'h57, 32'h40000010, 32'h0000022C, 32'h0, 1, 0, 1, 32'h0000004B};
    vecs[1] = '{8'h52, 32'h40000004, 32'h0, 32'hA1B2C3D4, 0, 1, 4, 32'hA1B2C3D4};
    vecs[2] = '{8'h00, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0000003F};
    vecs[3] = '{8'h57, 32'hFFFFFFFC, 32'hDEADBEEF, 32'h0, 1, 0, 1, 32'h0000004B};
    vecs[4] = '{8'h52, 32'h00000000, 32'h0, 32'h5A0FC3E1, 0, 1, 4, 32'h5A0FC3E1};
    vecs[5] = '{8'hFF, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h0000003F};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    rdata_val = 32'h0;
    repeat (3) @(negedge clk);
    check32("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check32("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    check32("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single commands.
    for (int v = 0; v < 6; v++) begin
      base_tx = tx_log.size();
      base_we = we_cnt;
      base_re = re_cnt;
      rdata_val = vecs[v].rdata;
      ha = (vecs[v].cmd == 8'h57) || (vecs[v].cmd == 8'h52);
      send_cmd(vecs[v].cmd, vecs[v].addr, vecs[v].data, ha, vecs[v].cmd == 8'h57);
      wait_idle($sformatf("v%0d_idle", v));
      check32($sformatf("v%0d_we_cnt", v), we_cnt - base_we, vecs[v].exp_we);
      check32($sformatf("v%0d_re_cnt", v), re_cnt - base_re, vecs[v].exp_re);
      check32($sformatf("v%0d_tx_cnt", v), tx_log.size() - base_tx, vecs[v].exp_n);
      check32($sformatf("v%0d_resp", v), resp_since(base_tx), vecs[v].exp_resp);
      if (vecs[v].exp_we == 1) begin
        check32($sformatf("v%0d_we_addr", v), we_addr, vecs[v].addr);
        check32($sformatf("v%0d_we_data", v), we_data, vecs[v].data);
      end
      if (vecs[v].exp_re == 1) check32($sformatf("v%0d_re_addr", v), re_addr, vecs[v].addr);
    end

    // Latency: mem_re the cycle after the last byte, tx_en one cycle later.
    base_tx = tx_log.size();
    rdata_val = 32'h11223344;
    send_byte(8'h52, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h00;
    @(negedge clk);
    rx_valid = 1'b0;
    check32("lat_mem_re", {31'd0, mem_re}, 32'd1);
    check32("lat_mem_addr", mem_addr, 32'h00000100);
    @(negedge clk);
    check32("lat_tx_en", {31'd0, tx_en}, 32'd1);
    check32("lat_tx_data", {24'd0, tx_data}, 32'h11);
    wait_idle("lat_idle");
    check32("lat_resp", resp_since(base_tx), 32'h11223344);

    // Timeout after a partial read, then a normal read.
    base_tx = tx_log.size();
    base_we = we_cnt;
    base_re = re_cnt;
    send_byte(8'h52, 1);
    send_byte(8'h40, 1);
    send_byte(8'h00, 0);
    repeat (99) @(negedge clk);
    check32("tmo_busy_before", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    check32("tmo_busy_after", {31'd0, busy}, 32'd0);
    check32("tmo_no_strobe", (we_cnt - base_we) + (re_cnt - base_re), 32'd0);
    check32("tmo_no_tx", tx_log.size() - base_tx, 32'd0);
    rdata_val = 32'h0BADF00D;
    send_cmd(8'h52, 32'h40000008, 32'h0, 1'b1, 1'b0);
    wait_idle("tmo_read_idle");
    check32("tmo_read_addr", re_addr, 32'h40000008);
    check32("tmo_read_resp", resp_since(base_tx), 32'h0BADF00D);

    // Overrun: a byte during the response is dropped.
    base_tx = tx_log.size();
    base_we = we_cnt;
    base_re = re_cnt;
    rdata_val = 32'hCAFEBABE;
    send_cmd(8'h52, 32'h40000000, 32'h0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    send_byte(8'h57, 0);
    wait_idle("ovr_idle");
    repeat (10) @(negedge clk);
    check32("ovr_busy", {31'd0, busy}, 32'd0);
    check32("ovr_tx_cnt", tx_log.size() - base_tx, 32'd4);
    check32("ovr_resp", resp_since(base_tx), 32'hCAFEBABE);
    check32("ovr_re_cnt", re_cnt - base_re, 32'd1);

    // Reset while waiting for the transmitter.
    base_tx = tx_log.size();
    rdata_val = 32'h12345678;
    send_cmd(8'h52, 32'h40000000, 32'h0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check32("rstw_busy", {31'd0, busy}, 32'd0);
    check32("rstw_tx_en", {31'd0, tx_en}, 32'd0);
    check32("rstw_tx_data", {24'd0, tx_data}, 32'd0);
    check32("rstw_mem_addr", mem_addr, 32'd0);
    check32("rstw_mem_wdata", mem_wdata, 32'd0);
    check32("rstw_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check32("rstw_tx_cnt", tx_log.size() - base_tx, 32'd1);
    check32("rstw_busy_late", {31'd0, busy}, 32'd0);

    // Auto-increment commands.
`ifdef UART_DBG_BRIDGE_AUTOINC_EN
    send_cmd(8'h57, 32'h40000000, 32'h11111111, 1'b1, 1'b1);
    wait_idle("ainc_w_idle");
    check32("ainc_w_addr", we_addr, 32'h40000000);
    base_tx = tx_log.size();
    send_cmd(8'h77, 32'h0, 32'h00000001, 1'b0, 1'b1);
    wait_idle("ainc_wi_idle");
    check32("ainc_wi_addr", we_addr, 32'h40000004);
    check32("ainc_wi_data", we_data, 32'h00000001);
    check32("ainc_wi_resp", resp_since(base_tx), 32'h0000004B);
`else
    base_tx = tx_log.size();
    base_we = we_cnt;
    base_re = re_cnt;
    send_byte(8'h77, 1);
    wait_idle("noinc_w_idle");
    check32("noinc_w_resp", resp_since(base_tx), 32'h0000003F);
    base_tx = tx_log.size();
    send_byte(8'h72, 1);
    wait_idle("noinc_r_idle");
    check32("noinc_r_resp", resp_since(base_tx), 32'h0000003F);
    check32("noinc_no_strobe", (we_cnt - base_we) + (re_cnt - base_re), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nerr);
    $finish;
  end

endmodule
